// File: rtl/line_cache_ring.sv
// line_cache_ring
//   Ring of NLINES complete video lines between a pixel producer and the scan-out reader.
//   The producer fills lines in order; the reader addresses the oldest completed line by
//   column, then releases it with line_advance. vsync flushes the whole ring.
//
// Ports
//   clk           clock, all state on posedge
//   reset         asynchronous, active-low reset
//   wr_valid      write pixel present
//   wr_ready      ring has a free line (lines_ready < NLINES)
//   wr_data       pixel value
//   wr_last       last pixel of the line, qualified by the write handshake
//   rd_en         read request for column hread_ptr of the oldest completed line
//   hread_ptr     column to read
//   line_advance  one-cycle pulse releasing the line being read
//   vsync         synchronous frame flush, highest priority
//   odata         registered read data (1-cycle latency)
//   odata_valid   odata holds cached data from this cycle's read
//   lines_ready   number of completed, unread lines
//   underrun      sticky: read attempted with no completed line
//   len_err       sticky: line closed with wr_last / column mismatch
module line_cache_ring #(
    parameter int unsigned NATIVE_HRES = 800,
    parameter int unsigned BITPERPIXEL = 12,
    parameter int unsigned NLINES      = 2,
    parameter int unsigned PTR_W       = 11,
    localparam int unsigned LR_W       = $clog2(NLINES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [BITPERPIXEL-1:0] wr_data,
    input  logic                   wr_last,
    input  logic                   rd_en,
    input  logic [PTR_W-1:0]       hread_ptr,
    input  logic                   line_advance,
    input  logic                   vsync,
    output logic [BITPERPIXEL-1:0] odata,
    output logic                   odata_valid,
    output logic [LR_W-1:0]        lines_ready,
    output logic                   underrun,
    output logic                   len_err
);

    localparam int unsigned IdxW  = (NLINES > 1) ? $clog2(NLINES) : 1;
    localparam int unsigned Depth = NLINES * NATIVE_HRES;
    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    localparam logic [PTR_W-1:0] LastCol  = PTR_W'(NATIVE_HRES - 1);
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NLINES - 1);
    localparam logic [LR_W-1:0]  FullCnt  = LR_W'(NLINES);
    localparam logic [AddrW-1:0] LineSize = AddrW'(NATIVE_HRES);

    // Line storage: flat synchronous-read array, no reset, so it maps onto block RAM.
    logic [BITPERPIXEL-1:0] mem [Depth];

    logic [IdxW-1:0]        wr_line_q, wr_line_d;
    logic [IdxW-1:0]        rd_line_q, rd_line_d;
    logic [PTR_W-1:0]       wr_col_q, wr_col_d;
    logic [LR_W-1:0]        lines_ready_q, lines_ready_d;
    logic                   underrun_q, underrun_d;
    logic                   len_err_q, len_err_d;
    logic                   odata_valid_q, odata_valid_d;
    // odata is the RAM output register masked by odata_zero_q; keeping the mask separate
    // lets the data register stay reset-free and inside the RAM primitive.
    logic                   odata_zero_q, odata_zero_d;
    logic [BITPERPIXEL-1:0] rdata_q;

    logic             has_line;
    logic             at_last_col;
    logic             wr_fire;
    logic             wr_close;
    logic             rd_advance;
    logic             rd_mem_en;
    logic [AddrW-1:0] wr_addr;
    logic [AddrW-1:0] rd_addr;

    assign has_line    = (lines_ready_q != '0);
    assign at_last_col = (wr_col_q == LastCol);
    assign wr_ready    = (lines_ready_q < FullCnt);

    // vsync drops any transfer in its cycle.
    assign wr_fire    = wr_valid && wr_ready && !vsync;
    assign wr_close   = wr_fire && (at_last_col || wr_last);
    assign rd_advance = line_advance && has_line && !vsync;
    assign rd_mem_en  = rd_en && has_line && (hread_ptr <= LastCol) && !vsync;

    assign wr_addr = AddrW'(wr_line_q) * LineSize + AddrW'(wr_col_q);
    assign rd_addr = AddrW'(rd_line_q) * LineSize + AddrW'(hread_ptr);

    always_comb begin
        wr_line_d     = wr_line_q;
        rd_line_d     = rd_line_q;
        wr_col_d      = wr_col_q;
        lines_ready_d = lines_ready_q;
        underrun_d    = underrun_q;
        len_err_d     = len_err_q;
        odata_valid_d = 1'b0;
        odata_zero_d  = odata_zero_q;

        if (vsync) begin
            wr_line_d     = '0;
            rd_line_d     = '0;
            wr_col_d      = '0;
            lines_ready_d = '0;
            underrun_d    = 1'b0;
            len_err_d     = 1'b0;
        end else begin
            if (wr_fire) begin
                if (wr_close) begin
                    wr_col_d  = '0;
                    wr_line_d = (wr_line_q == LastIdx) ? '0 : wr_line_q + IdxW'(1);
                end else begin
                    wr_col_d = wr_col_q + PTR_W'(1);
                end
                // Mismatch in either direction: early wr_last, or missing wr_last at the end.
                if (wr_last != at_last_col) begin
                    len_err_d = 1'b1;
                end
            end

            if (rd_advance) begin
                rd_line_d = (rd_line_q == LastIdx) ? '0 : rd_line_q + IdxW'(1);
            end

            // Close and release together leave the count unchanged.
            unique case ({wr_close, rd_advance})
                2'b10:   lines_ready_d = lines_ready_q + LR_W'(1);
                2'b01:   lines_ready_d = lines_ready_q - LR_W'(1);
                default: lines_ready_d = lines_ready_q;
            endcase

            if (rd_en) begin
                odata_valid_d = rd_mem_en;
                odata_zero_d  = !rd_mem_en;
                if (!has_line) begin
                    underrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_line_q     <= '0;
            rd_line_q     <= '0;
            wr_col_q      <= '0;
            lines_ready_q <= '0;
            underrun_q    <= 1'b0;
            len_err_q     <= 1'b0;
            odata_valid_q <= 1'b0;
            odata_zero_q  <= 1'b1;
        end else begin
            wr_line_q     <= wr_line_d;
            rd_line_q     <= rd_line_d;
            wr_col_q      <= wr_col_d;
            lines_ready_q <= lines_ready_d;
            underrun_q    <= underrun_d;
            len_err_q     <= len_err_d;
            odata_valid_q <= odata_valid_d;
            odata_zero_q  <= odata_zero_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_mem_en) begin
            rdata_q <= mem[rd_addr];
        end
    end

    assign odata       = odata_zero_q ? '0 : rdata_q;
    assign odata_valid = odata_valid_q;
    assign lines_ready = lines_ready_q;
    assign underrun    = underrun_q;
    assign len_err     = len_err_q;

endmodule

// File: doc/line_cache_ring.md
Name: line_cache_ring

Overview:
- Parametrised successor to the single-line pixel cache. It holds NLINES complete video lines in a ring of line buffers.
- Write side: a valid/ready pixel stream from the capture/decoder path fills lines in order.
- Read side: the scan-out timing generator reads the oldest completed line by column pointer, then releases it.
- Decouples producer and display timing by up to NLINES lines, with flow control, underrun/length error flags and a frame flush.

Parameters:
- NATIVE_HRES, 800, pixels per line (columns 0..NATIVE_HRES-1).
- BITPERPIXEL, 12, pixel width in bits.
- NLINES, 2, number of line buffers in the ring (>=2).
- PTR_W, 11, width of the column pointers; 2^PTR_W > NATIVE_HRES.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- wr_valid  in  1  write pixel present.
- wr_ready  out  1  cache can accept a pixel this cycle.
- wr_data  in  BITPERPIXEL  pixel value.
- wr_last  in  1  marks last pixel of a line; qualified by wr_valid&&wr_ready.
- rd_en  in  1  read request (h_sync_ref active region).
- hread_ptr  in  PTR_W  column to read.
- line_advance  in  1  one-cycle pulse: reader finished the current line.
- vsync  in  1  synchronous frame flush.
- odata  out  BITPERPIXEL  registered read data.
- odata_valid  out  1  odata holds real cached data.
- lines_ready  out  $clog2(NLINES+1)  count of completed, unread lines.
- underrun  out  1  sticky: read attempted with no completed line.
- len_err  out  1  sticky: line closed with wr_last/column mismatch.

Behaviour:
- Reset (reset=0, async): odata=0, odata_valid=0, lines_ready=0, underrun=0, len_err=0, write/read line indices=0, wr_col=0. Memory contents are not reset; the memory is a synchronous-read array, BRAM-inferable.
- wr_ready = (lines_ready < NLINES). Purely combinational from the registered count.
- Write accept (wr_valid && wr_ready):
  - Writes mem[wr_line][wr_col] <= wr_data.
  - The line closes when wr_col==NATIVE_HRES-1 or wr_last=1.
  - On close: wr_col<=0, wr_line<=(wr_line+1) mod NLINES, lines_ready increments.
  - If not closing: wr_col increments.
  - len_err is set if wr_last=1 with wr_col!=NATIVE_HRES-1, or if wr_col==NATIVE_HRES-1 with wr_last=0.
  - Short lines keep stale content in the unwritten columns.
- Read:
  - With rd_en=1 and lines_ready>0, odata <= mem[rd_line][hread_ptr] and odata_valid <= 1. Latency is 1 cycle.
  - If hread_ptr >= NATIVE_HRES, odata <= 0 and odata_valid <= 0.
  - With rd_en=1 and lines_ready==0, odata <= 0, odata_valid <= 0, and underrun <= 1.
  - With rd_en=0, odata holds its value and odata_valid <= 0.
- line_advance:
  - If lines_ready>0: rd_line <= (rd_line+1) mod NLINES and lines_ready decrements.
  - If lines_ready==0: ignored, with no flag.
- Simultaneous write-close and line_advance: lines_ready is unchanged and both indices advance.
- rd_en in the same cycle as line_advance reads the line being released (old rd_line).
- The reader never sees a partially written line. The only time wr_line==rd_line with lines_ready>0 is when the ring is full, and writes are then blocked.
- vsync=1 (highest synchronous priority):
  - Sets lines_ready=0, wr_line=rd_line=0, wr_col=0; clears underrun and len_err; odata_valid <= 0.
  - Any write or read in that cycle is dropped.
- Wrap-around: indices wrap NLINES-1 -> 0. lines_ready saturates by construction and never exceeds NLINES.
- Reset asserted mid-line: the partial line is discarded and all state returns to reset values.

Test Plan:
- Reset release, write 800 pixels (data=column index, wr_last on col 799) -> lines_ready=1, len_err=0. Then rd_en with hread_ptr=5 -> odata=5, odata_valid=1 one cycle later.
- Fill 2 lines with NLINES=2, keep wr_valid=1 -> wr_ready=0 and lines_ready=2. Then pulse line_advance -> wr_ready=1 next cycle, and the third line is written into buffer 0.
- rd_en=1 with lines_ready=0 -> odata=0, odata_valid=0, underrun=1. underrun stays 1 until a vsync pulse, then reads 0.
- wr_last at col 399 -> line closes, len_err=1, lines_ready increments, next pixel lands at col 0 of the next buffer. Reading col 500 of the short line returns stale content.
- Write-close in the same cycle as line_advance with lines_ready=1 -> lines_ready stays 1, and reads return the newly completed line. hread_ptr=800 -> odata=0, odata_valid=0.
- Assert reset=0 asynchronously mid-line (col 300) -> outputs and counts go to 0 before the next clk edge. After release, the first write goes to line 0 col 0.
